// File: rtl/differentiator_back.sv
// ---------------------------------------------------------------------------
// differentiator_back
//
// Backward-difference differentiator y[n] = x[n] - x[n-1] on signed PCM
// samples. Samples are framed by the slow strobe CLK_I, which is oversampled
// by MCLK_I. The block is meant to follow the companion forward integrator in
// the same MCLK_I domain, so that integrator + differentiator reproduces the
// integrator's input.
//
// Optional feature macro: DIFFERENTIATOR_BACK_WRAPAROUND_EN
//   undefined (default) : out-of-range differences saturate to max/min
//   defined             : out-of-range differences wrap (two's complement)
//   The overflow/underflow flags report the out-of-range condition either way.
//
// Parameters
//   DATA_BIT_WIDTH : signed sample width of DATA_I / DATA_O (>= 2)
//   LATCH_LENGTH   : MCLK_I stages CLK_I passes before its rising edge is
//                    acted on (>= 1)
//
// Ports
//   MCLK_I   in   master clock, all logic on its rising edge
//   NRST_I   in   asynchronous active-low reset
//   CLK_I    in   sample strobe, rising edge marks a new sample
//   DATA_I   in   signed input sample x[n]
//   CLK_O    out  sample strobe re-timed to align with DATA_O
//   DATA_O   out  signed difference y[n]
//   OFDET_O  out  difference exceeded the positive maximum this sample
//   UFDET_O  out  difference fell below the negative minimum this sample
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module differentiator_back #(
  parameter int DATA_BIT_WIDTH = 32,
  parameter int LATCH_LENGTH   = 1
) (
  input  logic                      MCLK_I,
  input  logic                      NRST_I,
  input  logic                      CLK_I,
  input  logic [DATA_BIT_WIDTH-1:0] DATA_I,
  output logic                      CLK_O,
  output logic [DATA_BIT_WIDTH-1:0] DATA_O,
  output logic                      OFDET_O,
  output logic                      UFDET_O
);

  localparam int W = DATA_BIT_WIDTH;

  localparam logic [W-1:0] MAX_VAL = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};

  logic [LATCH_LENGTH+1:0] strobe_sr;
  logic                    update_evt;
  logic [W-1:0]            x_prev;
  logic [W:0]              diff_ext;
  logic                    over_pos;
  logic                    over_neg;
  logic [W-1:0]            diff_out;

  // Strobe pipeline: CLK_I is shifted through MCLK_I stages; it also acts as
  // the synchroniser for the asynchronous strobe and gives DATA_I time to
  // settle before it is sampled.
  always_ff @(posedge MCLK_I or negedge NRST_I) begin
    if (!NRST_I) begin
      strobe_sr <= '0;
    end else begin
      strobe_sr <= {strobe_sr[LATCH_LENGTH:0], CLK_I};
    end
  end

  // A rising edge seen between stages LATCH_LENGTH-1 and LATCH_LENGTH
  // triggers the update. The outgoing strobe is taken one stage later, so
  // DATA_O and the flags are settled a full MCLK_I cycle before CLK_O rises.
  assign update_evt = strobe_sr[LATCH_LENGTH-1] & ~strobe_sr[LATCH_LENGTH];
  assign CLK_O      = strobe_sr[LATCH_LENGTH+1];

  // Difference computed one bit wider so the true result is always
  // representable; the top two bits disagreeing marks an out-of-range result.
  assign diff_ext = {DATA_I[W-1], DATA_I} - {x_prev[W-1], x_prev};
  assign over_pos = ~diff_ext[W] &  diff_ext[W-1];
  assign over_neg =  diff_ext[W] & ~diff_ext[W-1];

  // Output value selection: wrap keeps the low W bits, default clamps.
  always_comb begin
    diff_out = diff_ext[W-1:0];
`ifdef DIFFERENTIATOR_BACK_WRAPAROUND_EN
    diff_out = diff_ext[W-1:0];
`else
    if (over_pos) begin
      diff_out = MAX_VAL;
    end else if (over_neg) begin
      diff_out = MIN_VAL;
    end
`endif
  end

  // Sample register and outputs: everything holds between update events.
  always_ff @(posedge MCLK_I or negedge NRST_I) begin
    if (!NRST_I) begin
      x_prev  <= '0;
      DATA_O  <= '0;
      OFDET_O <= 1'b0;
      UFDET_O <= 1'b0;
    end else if (update_evt) begin
      x_prev  <= DATA_I;
      DATA_O  <= diff_out;
      OFDET_O <= over_pos;
      UFDET_O <= over_neg;
    end
  end

endmodule

// File: tb/tb_differentiator_back.sv
// ---------------------------------------------------------------------------
// tb_differentiator_back
//
// Self-checking bench for differentiator_back with W=5, LATCH_LENGTH=1,
// MCLK_I period 2 ns, CLK_I period about 64 ns. Expected outputs are pushed to
// a queue when a sample is driven and popped when CLK_O rises. The cascade
// section models the companion saturating integrator in front of the DUT.
// Honours DIFFERENTIATOR_BACK_WRAPAROUND_EN for the out-of-range expectations.
// ---------------------------------------------------------------------------
`timescale 1ns/100ps

module tb_differentiator_back;

  localparam int W  = 5;
  localparam int LL = 1;

  logic         mclk    = 1'b0;
  logic         nrst    = 1'b1;
  logic         clk_in  = 1'b0;
  logic [W-1:0] data_in = 5'sd7;
  logic         clk_out;
  logic [W-1:0] data_out;
  logic         of_det;
  logic         uf_det;

  typedef struct packed {
    logic [W-1:0] data;
    logic         of;
    logic         uf;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   total_checks = 0;
  int   bad_checks   = 0;
  logic clk_out_prev = 1'b0;
  int   acc;
  int   sum;
  int   in_val;
  logic [W-1:0] exp_val;

  differentiator_back #(
    .DATA_BIT_WIDTH (W),
    .LATCH_LENGTH   (LL)
  ) dut (
    .MCLK_I  (mclk),
    .NRST_I  (nrst),
    .CLK_I   (clk_in),
    .DATA_I  (data_in),
    .CLK_O   (clk_out),
    .DATA_O  (data_out),
    .OFDET_O (of_det),
    .UFDET_O (uf_det)
  );

  always #1 mclk = ~mclk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    total_checks++;
    if (observed !== expected) begin
      bad_checks++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Scoreboard consumer: on every CLK_O rise, compare against the oldest
  // expected sample; a rise with nothing expected is itself a failure.
  always @(negedge mclk) begin
    if (nrst && clk_out && !clk_out_prev) begin
      if (exp_q.size() == 0) begin
        check_output("unexpected_clk_o", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check_output("data_o", {27'd0, data_out}, {27'd0, mon_e.data});
        check_output("ofdet_o", {31'd0, of_det}, {31'd0, mon_e.of});
        check_output("ufdet_o", {31'd0, uf_det}, {31'd0, mon_e.uf});
      end
    end
    clk_out_prev = clk_out;
  end

  task automatic check_all_zero(input string tag);
    check_output({tag, "_data"}, {27'd0, data_out}, 32'd0);
    check_output({tag, "_clk"}, {31'd0, clk_out}, 32'd0);
    check_output({tag, "_of"}, {31'd0, of_det}, 32'd0);
    check_output({tag, "_uf"}, {31'd0, uf_det}, 32'd0);
  endtask

  // One full CLK_I period carrying sample x, with its expected result queued.
  task automatic apply_stimulus(input logic [W-1:0] x, input logic [W-1:0] exp_data,
                                input logic exp_of, input logic exp_uf);
    exp_t e;
    @(negedge mclk);
    data_in = x;
    e.data  = exp_data;
    e.of    = exp_of;
    e.uf    = exp_uf;
    exp_q.push_back(e);
    clk_in = 1'b1;
    #32;
    clk_in = 1'b0;
    #32;
  endtask

  // Asynchronous reset pulse in the strobe low phase; outputs must clear at once.
  task automatic pulse_reset(input string tag, input realtime width);
    #3.3;
    nrst = 1'b0;
    #0.2;
    check_all_zero(tag);
    exp_q.delete();
    #(width);
    nrst = 1'b1;
    #6;
  endtask

  // First sample after reset with edge-accurate timing checks.
  task automatic first_sample_timing();
    exp_t e;
    @(negedge mclk);
    data_in = 5'sd7;
    e.data  = 5'sd7;
    e.of    = 1'b0;
    e.uf    = 1'b0;
    exp_q.push_back(e);
    clk_in = 1'b1;
    @(posedge mclk);
    #0.5;
    check_output("edge1_data", {27'd0, data_out}, 32'd0);
    check_output("edge1_clk", {31'd0, clk_out}, 32'd0);
    @(posedge mclk);
    #0.5;
    check_output("edge2_data", {27'd0, data_out}, 32'd7);
    check_output("edge2_clk", {31'd0, clk_out}, 32'd0);
    @(posedge mclk);
    #0.5;
    check_output("edge3_clk", {31'd0, clk_out}, 32'd1);
    #26.5;
    clk_in = 1'b0;
    #32;
  endtask

  // Reset lands between the CLK_I rise and its update edge; the sample must
  // be dropped and CLK_O must stay low.
  task automatic mid_sample_reset();
    @(negedge mclk);
    data_in = 5'sd9;
    clk_in  = 1'b1;
    @(posedge mclk);
    #0.5;
    nrst = 1'b0;
    #0.2;
    check_all_zero("mid_rst");
    exp_q.delete();
    #30;
    clk_in = 1'b0;
    #10;
    nrst = 1'b1;
    #20;
    check_output("mid_rst_after_clk", {31'd0, clk_out}, 32'd0);
    check_output("mid_rst_after_data", {27'd0, data_out}, 32'd0);
  endtask

  initial begin
    // Reset with DATA_I held at 7.
    #3.5;
    nrst = 1'b0;
    #0.2;
    check_all_zero("init_rst");
    #2.3;
    nrst = 1'b1;

    first_sample_timing();

    // Ramp: one step per sample.
    apply_stimulus(5'sd0, -5'sd7, 1'b0, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      apply_stimulus(5'(i), 5'sd1, 1'b0, 1'b0);
    end

    apply_stimulus(-5'sd8, -5'sd13, 1'b0, 1'b0);
    apply_stimulus(-5'sd16, -5'sd8, 1'b0, 1'b0);
`ifdef DIFFERENTIATOR_BACK_WRAPAROUND_EN
    apply_stimulus(5'sd15, -5'sd1, 1'b1, 1'b0);
    apply_stimulus(5'sd15, 5'sd0, 1'b0, 1'b0);
    apply_stimulus(-5'sd16, 5'sd1, 1'b0, 1'b1);
    apply_stimulus(5'sd0, -5'sd16, 1'b1, 1'b0);
`else
    apply_stimulus(5'sd15, 5'sd15, 1'b1, 1'b0);
    apply_stimulus(5'sd15, 5'sd0, 1'b0, 1'b0);
    apply_stimulus(-5'sd16, -5'sd16, 1'b0, 1'b1);
    apply_stimulus(5'sd0, 5'sd15, 1'b1, 1'b0);
`endif
    // Exact range limits produce no flags.
    apply_stimulus(5'sd15, 5'sd15, 1'b0, 1'b0);
    apply_stimulus(-5'sd1, -5'sd16, 1'b0, 1'b0);

    // Reset while outputs are non-zero, then first sample is DATA_I - 0.
    pulse_reset("nz_rst", 5.0);
    apply_stimulus(5'sd4, 5'sd4, 1'b0, 1'b0);

    mid_sample_reset();
    apply_stimulus(5'sd3, 5'sd3, 1'b0, 1'b0);

    // Cascade with a saturating integrator model feeding DATA_I.
    acc = 0;
    for (int n = 0; n < 1000; n++) begin
      if (n % 455 == 0) begin
        pulse_reset("cascade_rst", 20.0);
        acc = 0;
      end
      in_val = ((n / 64) % 2 == 0) ? -1 : 1;
      sum = acc + in_val;
      if (sum > 15) begin
        acc     = 15;
        exp_val = 5'sd0;
      end else if (sum < -16) begin
        acc     = -16;
        exp_val = 5'sd0;
      end else begin
        acc     = sum;
        exp_val = 5'(in_val);
      end
      apply_stimulus(acc[W-1:0], exp_val, 1'b0, 1'b0);
    end

    // Bounded drain of any outstanding expectations.
    repeat (20) @(negedge mclk);
    check_output("queue_drain", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

endmodule
